// File: rtl/keypad_scan_ctrl_if.sv
// Keypad controller signal bundle: row lines in, column drive and key reporting out.
// master is the scan controller; slave is the keypad/consumer side.
interface keypad_scan_ctrl_if;
  logic [3:0] rows_sync;
  logic [3:0] cols;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  modport master (
    input  rows_sync,
    output cols, key_valid, key_code, key_held
  );

  modport slave (
    output rows_sync,
    input  cols, key_valid, key_code, key_held
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with press/release debounce.
// Emits one key_valid pulse and a latched key_code per debounced press.
module keypad_scan_ctrl #(
  parameter int unsigned SETTLE    = 4,
  parameter int unsigned DB_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  keypad_scan_ctrl_if.master  kp
);

  localparam int unsigned CNT_MAX = (SETTLE > DB_CYCLES) ? SETTLE : DB_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] DB_LAST     = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    pat_q, pat_d;
  logic [1:0]    row_q, row_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_held_q, key_held_d;

  logic          accept;
  logic          release_done;
  logic [1:0]    low_row;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      cnt_q       <= '0;
      col_q       <= '0;
      pat_q       <= '1;
      row_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      pat_q       <= pat_d;
      row_q       <= row_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
    end
  end

  // Lowest closed row wins when several rows of one column are pulled low.
  always_comb begin
    if (!kp.rows_sync[0])      low_row = 2'd0;
    else if (!kp.rows_sync[1]) low_row = 2'd1;
    else if (!kp.rows_sync[2]) low_row = 2'd2;
    else                       low_row = 2'd3;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    col_d        = col_q;
    pat_d        = pat_q;
    row_d        = row_q;
    accept       = 1'b0;
    release_done = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (kp.rows_sync == 4'b1111) begin
            col_d = col_q + 2'd1;
          end else begin
            pat_d   = kp.rows_sync;
            row_d   = low_row;
            state_d = PRESS_DB;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESS_DB: begin
        if (kp.rows_sync == pat_q) begin
          if (cnt_q == DB_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
            accept  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          state_d = SCAN;
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
        end
      end
      HELD: begin
        if (kp.rows_sync == 4'b1111) begin
          if (cnt_q == DB_LAST) begin
            state_d      = SCAN;
            cnt_d        = '0;
            col_d        = col_q + 2'd1;
            release_done = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    key_valid_d = accept;
    key_code_d  = accept ? {row_q, col_q} : key_code_q;
    if (accept)            key_held_d = 1'b1;
    else if (release_done) key_held_d = 1'b0;
    else                   key_held_d = key_held_q;
  end

  assign kp.cols      = ~(4'b0001 << col_q);
  assign kp.key_valid = key_valid_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a column-aware keypad model (SETTLE=4, DB_CYCLES=8).
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] keys [4];
  int         vectors;
  int         miscompares;
  int         pulses;

  keypad_scan_ctrl_if kif ();

  keypad_scan_ctrl #(.SETTLE(4), .DB_CYCLES(8)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif)
  );

  // A row is pulled low only when a closed key sits in the currently driven column.
  assign kif.rows_sync = {~|(keys[3] & ~kif.cols), ~|(keys[2] & ~kif.cols),
                          ~|(keys[1] & ~kif.cols), ~|(keys[0] & ~kif.cols)};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cols(input logic [3:0] c);
    int n;
    n = 0;
    while (kif.cols !== c && n < 40) begin
      tick(1);
      n++;
    end
    chk("poll_cols", kif.cols, c);
  endtask

  task automatic count_pulses(input int n);
    pulses = 0;
    repeat (n) begin
      tick(1);
      if (kif.key_valid === 1'b1) pulses++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_cols;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    for (int r = 0; r < 4; r++) keys[r] = 4'b0000;

    // 1: reset and free-running scan
    tick(2);
    chk("rst_cols", kif.cols, 4'b1110);
    chk("rst_valid", kif.key_valid, 1'b0);
    chk("rst_code", kif.key_code, 4'h0);
    chk("rst_held", kif.key_held, 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 17; k++) begin
      exp_cols = ~(4'b0001 << ((k / 4) % 4));
      chk("scan_cols", kif.cols, exp_cols);
      tick(1);
    end

    // 2: stable press row1/col2
    keys[1] = 4'b0100;
    wait_cols(4'b1011);
    for (int i = 1; i < 12; i++) begin
      tick(1);
      chk("press_wait_valid", kif.key_valid, 1'b0);
    end
    tick(1);
    chk("press_valid", kif.key_valid, 1'b1);
    chk("press_code", kif.key_code, 4'h6);
    chk("press_held", kif.key_held, 1'b1);
    chk("press_cols", kif.cols, 4'b1011);
    tick(1);
    chk("press_valid_1cyc", kif.key_valid, 1'b0);
    count_pulses(100);
    chk("hold_no_repulse", pulses, 0);
    chk("hold_cols", kif.cols, 4'b1011);
    chk("hold_held", kif.key_held, 1'b1);

    // 4: release with a one-cycle glitch
    keys[1] = 4'b0000;
    tick(5);
    chk("rel_pre_glitch_held", kif.key_held, 1'b1);
    keys[1] = 4'b0100;
    tick(1);
    chk("rel_glitch_held", kif.key_held, 1'b1);
    keys[1] = 4'b0000;
    tick(7);
    chk("rel_7_held", kif.key_held, 1'b1);
    chk("rel_7_cols", kif.cols, 4'b1011);
    tick(1);
    chk("rel_8_held", kif.key_held, 1'b0);
    chk("rel_8_cols", kif.cols, 4'b0111);
    chk("rel_8_code", kif.key_code, 4'h6);
    chk("rel_8_valid", kif.key_valid, 1'b0);

    // 3: bounce on row1/col2
    wait_cols(4'b1011);
    keys[1] = 4'b0100;
    tick(4);
    chk("bounce_db_cols", kif.cols, 4'b1011);
    chk("bounce_db_valid", kif.key_valid, 1'b0);
    tick(3);
    chk("bounce_low3_cols", kif.cols, 4'b1011);
    chk("bounce_low3_valid", kif.key_valid, 1'b0);
    keys[1] = 4'b0000;
    tick(1);
    chk("bounce_cols", kif.cols, 4'b0111);
    chk("bounce_valid", kif.key_valid, 1'b0);
    chk("bounce_code", kif.key_code, 4'h6);
    chk("bounce_held", kif.key_held, 1'b0);

    // 5: multi-row press in col1, then a new key while held
    keys[0] = 4'b0010;
    keys[2] = 4'b0010;
    wait_cols(4'b1101);
    tick(11);
    chk("multi_wait_valid", kif.key_valid, 1'b0);
    tick(1);
    chk("multi_valid", kif.key_valid, 1'b1);
    chk("multi_code", kif.key_code, 4'h1);
    chk("multi_held", kif.key_held, 1'b1);
    chk("multi_cols", kif.cols, 4'b1101);
    keys[3] = 4'b0001;
    count_pulses(20);
    chk("rollover_no_pulse", pulses, 0);
    chk("rollover_cols", kif.cols, 4'b1101);
    chk("rollover_code", kif.key_code, 4'h1);
    keys[0] = 4'b0000;
    keys[2] = 4'b0000;
    tick(8);
    chk("multi_rel_held", kif.key_held, 1'b0);
    chk("multi_rel_cols", kif.cols, 4'b1011);
    tick(19);
    chk("second_wait_valid", kif.key_valid, 1'b0);
    tick(1);
    chk("second_valid", kif.key_valid, 1'b1);
    chk("second_code", kif.key_code, 4'hC);
    chk("second_cols", kif.cols, 4'b1110);
    chk("second_held", kif.key_held, 1'b1);

    // 6: reset during HELD, then during PRESS_DB
    tick(2);
    reset = 1'b1;
    tick(1);
    chk("rst_held_cols", kif.cols, 4'b1110);
    chk("rst_held_held", kif.key_held, 1'b0);
    chk("rst_held_valid", kif.key_valid, 1'b0);
    chk("rst_held_code", kif.key_code, 4'h0);
    reset   = 1'b0;
    keys[3] = 4'b0000;
    keys[1] = 4'b0100;
    wait_cols(4'b1011);
    tick(5);
    chk("pdb_valid", kif.key_valid, 1'b0);
    chk("pdb_cols", kif.cols, 4'b1011);
    reset = 1'b1;
    tick(1);
    chk("rst_pdb_cols", kif.cols, 4'b1110);
    chk("rst_pdb_valid", kif.key_valid, 1'b0);
    chk("rst_pdb_held", kif.key_held, 1'b0);
    chk("rst_pdb_code", kif.key_code, 4'h0);
    reset   = 1'b0;
    keys[1] = 4'b0000;
    tick(3);
    chk("restart_col0", kif.cols, 4'b1110);
    tick(1);
    chk("restart_col1", kif.cols, 4'b1101);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
